// File: rtl/pixel_if_pkg.sv
// Shared types and constants for the pixel-append interface (add strobe + 12-bit RGB).
// Imported by the transmit-side FSM and its input FIFO.
package pixel_if_pkg;

  localparam int RGB_W  = 12;
  localparam int IDX_W  = 11;
  localparam int PW_DEF = 40;
  localparam int PH_DEF = 30;

  // Field MSBs inside an RGB word {R, G, B}, each field 4 bits wide.
  localparam int R_MSB = 11;
  localparam int G_MSB = 7;
  localparam int B_MSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP,
    ST_CLEAR
  } tx_state_t;

  typedef logic [RGB_W-1:0] rgb_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic rgb_t rgb_pack(input logic [3:0] r, input logic [3:0] g,
                                    input logic [3:0] b);
    rgb_t w;
    w = '0;
    w[R_MSB -: 4] = r;
    w[G_MSB -: 4] = g;
    w[B_MSB -: 4] = b;
    return w;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock FIFO with flush; a written word becomes readable (empty=0) one cycle later.
// full is registered, so a pop frees space only on the following cycle.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_next;
  logic             do_wr;
  logic             do_rd;

  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_en && !empty && !flush;
  assign rd_dat = mem[rd_ptr];

  // A word written alongside a flush lands in slot 0 of the emptied buffer.
  always_comb begin
    cnt_next = count;
    if (flush) begin
      cnt_next = do_wr ? (AW+1)'(1) : '0;
    end else if (do_wr && !do_rd) begin
      cnt_next = count + 1'b1;
    end else if (!do_wr && do_rd) begin
      cnt_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= do_wr ? AW'(1) : '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + 1'b1;
        if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
      count <= cnt_next;
      full  <= (cnt_next == (AW+1)'(DEPTH));
      // Falls only once the count has been non-zero for a full cycle.
      empty <= (cnt_next == '0) || (count == '0) || flush;
    end
  end

  always_ff @(posedge clk_50) begin
    if (do_wr) mem[flush ? AW'(0) : wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Replays buffered RGB words as add pulses with fixed hold/gap, mirroring the receiver's index.
// First pulse two cycles after acceptance; one pixel per 1+HOLD+GAP cycles; in_ready = FIFO not full.
module pixel_stream_tx
  import pixel_if_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int CLR_CYCLES  = 2,
  parameter int PW          = PW_DEF,
  parameter int PH          = PH_DEF
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RGB_W-1:0] in_rgb,
  input  logic             in_clear,
  output logic             out_add,
  output logic [RGB_W-1:0] out_rgb,
  output logic             out_reset,
  output logic [IDX_W-1:0] pix_index,
  output logic             frame_done,
  output logic             busy
);

  localparam int NPIX = PW * PH;
  localparam int MAXC = max3(HOLD_CYCLES, GAP_CYCLES, CLR_CYCLES);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  tx_state_t               state;
  tx_state_t               state_nxt;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_nxt;
  logic                    clear_pending;
  logic                    clear_pending_nxt;
  logic                    out_add_nxt;
  logic                    out_reset_nxt;
  logic                    frame_done_nxt;
  logic [RGB_W-1:0]        out_rgb_nxt;
  logic [IDX_W-1:0]        pix_index_nxt;
  logic                    last_idx;
  logic                    fifo_pop;
  logic [RGB_W-1:0]        fifo_dat;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RGB_W)
  ) u_fifo (
    .clk_50 (clk_50),
    .reset  (reset),
    .flush  (in_clear),
    .wr_vld (in_valid),
    .wr_dat (in_rgb),
    .rd_en  (fifo_pop),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign busy     = (fifo_count != '0) || (state != ST_IDLE) || clear_pending;
  assign last_idx = (pix_index == IDX_W'(NPIX - 1));

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    clear_pending_nxt = clear_pending;
    out_add_nxt       = out_add;
    out_rgb_nxt       = out_rgb;
    out_reset_nxt     = out_reset;
    pix_index_nxt     = pix_index;
    frame_done_nxt    = 1'b0;
    fifo_pop          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clear_pending) begin
          state_nxt         = ST_CLEAR;
          out_reset_nxt     = 1'b1;
          clear_pending_nxt = 1'b0;
          pix_index_nxt     = '0;
          cnt_nxt           = '0;
        end else if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          out_rgb_nxt = fifo_dat;
          out_add_nxt = 1'b1;
          state_nxt   = ST_HOLD;
          cnt_nxt     = '0;
        end
      end
      ST_HOLD: begin
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          out_add_nxt    = 1'b0;
          pix_index_nxt  = last_idx ? '0 : pix_index + 1'b1;
          frame_done_nxt = last_idx;
          state_nxt      = ST_GAP;
          cnt_nxt        = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_CLEAR: begin
        pix_index_nxt = '0;
        if (cnt == CW'(CLR_CYCLES - 1)) begin
          out_reset_nxt = 1'b0;
          state_nxt     = ST_IDLE;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A new request re-arms even while a clear is being taken or running.
    if (in_clear) clear_pending_nxt = 1'b1;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      clear_pending <= 1'b0;
      out_add       <= 1'b0;
      out_rgb       <= '0;
      out_reset     <= 1'b0;
      pix_index     <= '0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      clear_pending <= clear_pending_nxt;
      out_add       <= out_add_nxt;
      out_rgb       <= out_rgb_nxt;
      out_reset     <= out_reset_nxt;
      pix_index     <= pix_index_nxt;
      frame_done    <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pixel_stream_tx;

  localparam int DEPTH = 8;
  localparam int HOLD  = 2;
  localparam int GAP   = 2;
  localparam int CLR   = 2;
  localparam int NPIX  = 40 * 30;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_rgb;
  logic        in_clear;
  logic        out_add;
  logic [11:0] out_rgb;
  logic        out_reset;
  logic [10:0] pix_index;
  logic        frame_done;
  logic        busy;

  pixel_stream_tx dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rgb     (in_rgb),
    .in_clear   (in_clear),
    .out_add    (out_add),
    .out_rgb    (out_rgb),
    .out_reset  (out_reset),
    .pix_index  (pix_index),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #10 clk_50 = ~clk_50;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit started = 0;

  // Reference model: queue of words with the edge at which each becomes poppable,
  // and the most recent sequencer event (1 = pixel, 2 = clear) with its start edge.
  logic [11:0] mq[$];
  int          mvis[$];
  int          m_next, m_ev, m_ev_s, m_inc_at, m_idx;
  logic [11:0] m_rgb;
  bit          m_pend, m_fd;

  // DUT activity counters
  int  n_pulse = 0, n_rst = 0, n_fd = 0;
  bit  prev_add = 0;
  bit  saw_full = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_step();
    bit room;
    cyc++;
    if (reset) begin
      mq.delete(); mvis.delete();
      m_next = cyc + 1; m_ev = 0; m_ev_s = 0; m_inc_at = -1;
      m_idx = 0; m_rgb = '0; m_pend = 0; m_fd = 0; started = 1;
      return;
    end
    room = mq.size() < DEPTH;
    m_fd = 0;
    if (cyc == m_inc_at) begin
      m_fd  = (m_idx == NPIX - 1);
      m_idx = m_fd ? 0 : m_idx + 1;
    end
    if (cyc >= m_next) begin
      if (m_pend) begin
        m_ev = 2; m_ev_s = cyc; m_pend = 0; m_idx = 0;
        m_next = cyc + CLR + 1;
      end else if (mq.size() > 0 && mvis[0] <= cyc) begin
        m_rgb = mq.pop_front();
        void'(mvis.pop_front());
        m_ev = 1; m_ev_s = cyc; m_inc_at = cyc + HOLD;
        m_next = cyc + HOLD + GAP + 1;
      end
    end
    if (in_clear) begin
      mq.delete(); mvis.delete(); m_pend = 1;
    end
    if (in_valid && room) begin
      mq.push_back(in_rgb);
      mvis.push_back(cyc + 2);
    end
  endtask

  task automatic compare_step();
    chk("out_add",    int'(out_add),    int'(m_ev == 1 && (cyc - m_ev_s) < HOLD));
    chk("out_reset",  int'(out_reset),  int'(m_ev == 2 && (cyc - m_ev_s) < CLR));
    chk("out_rgb",    int'(out_rgb),    int'(m_rgb));
    chk("pix_index",  int'(pix_index),  m_idx);
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("in_ready",   int'(in_ready),   int'(mq.size() < DEPTH));
    chk("busy",       int'(busy),       int'(mq.size() > 0 || m_next > cyc + 1 || m_pend));
    if (out_add && !prev_add) n_pulse++;
    if (out_reset) n_rst++;
    if (frame_done) n_fd++;
    prev_add = out_add;
  endtask

  always @(posedge clk_50) model_step();
  always @(negedge clk_50) if (started) compare_step();

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [11:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_rgb   = w;
    while (!in_ready && t < 200) begin
      saw_full = 1;
      @(negedge clk_50);
      t++;
    end
    chk("send_accept", int'(in_ready), 1);
    @(negedge clk_50);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk_50);
      t++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk_50);
    reset = 1'b0;
  endtask

  initial begin
    int b_pulse, b_rst, b_fd;
    reset = 1'b1; in_valid = 1'b0; in_rgb = '0; in_clear = 1'b0;
    repeat (3) @(negedge clk_50);
    chk("rst_out_add", int'(out_add), 0);
    chk("rst_out_rgb", int'(out_rgb), 0);
    chk("rst_pix_index", int'(pix_index), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk_50);

    // Single pixel: accepted at edge t, high after t+2 and t+3.
    b_fd = n_fd;
    send(12'hF0A);
    @(negedge clk_50); chk("single_add_t1", int'(out_add), 0);
    @(negedge clk_50); chk("single_add_t2", int'(out_add), 1);
    chk("single_rgb", int'(out_rgb), 12'hF0A);
    @(negedge clk_50); chk("single_add_t3", int'(out_add), 1);
    @(negedge clk_50); chk("single_add_t4", int'(out_add), 0);
    chk("single_idx", int'(pix_index), 1);
    chk("single_rgb_gap", int'(out_rgb), 12'hF0A);
    wait_idle();
    chk("single_no_fd", n_fd - b_fd, 0);

    // Burst with backpressure.
    saw_full = 0;
    b_pulse = n_pulse;
    for (int i = 0; i < 12; i++) send(12'($urandom_range(0, 4095)));
    wait_idle();
    chk("burst_backpressure", int'(saw_full), 1);
    chk("burst_pulses", n_pulse - b_pulse, 12);
    chk("burst_idx", int'(pix_index), 13);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_rgb   = 12'($urandom_range(0, 4095));
      in_clear = ($urandom_range(0, 59) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      @(negedge clk_50);
    end
    in_valid = 1'b0; in_clear = 1'b0; reset = 1'b0;
    wait_idle();

    // Frame wrap.
    pulse_reset();
    for (int i = 0; i < NPIX - 2; i++) send(12'($urandom_range(0, 4095)));
    wait_idle();
    chk("wrap_pre_idx", int'(pix_index), 1198);
    b_fd = n_fd;
    for (int i = 0; i < 3; i++) send(12'($urandom_range(0, 4095)));
    wait_idle();
    chk("wrap_fd_once", n_fd - b_fd, 1);
    chk("wrap_idx", int'(pix_index), 1);

    // Clear during the first HOLD.
    b_pulse = n_pulse; b_rst = n_rst;
    for (int i = 0; i < 4; i++) send(12'h300 + 12'(i));
    chk("clr_mid_in_hold", int'(out_add), 1);
    in_clear = 1'b1;
    @(negedge clk_50);
    in_clear = 1'b0;
    wait_idle();
    chk("clr_mid_pulses", n_pulse - b_pulse, 1);
    chk("clr_mid_rst_cycles", n_rst - b_rst, 2);
    chk("clr_mid_idx", int'(pix_index), 0);

    // Clear with a same-edge push while two words are queued.
    b_pulse = n_pulse; b_rst = n_rst;
    for (int i = 0; i < 3; i++) send(12'h500 + 12'(i));
    in_valid = 1'b1; in_rgb = 12'h123; in_clear = 1'b1;
    @(negedge clk_50);
    in_valid = 1'b0; in_clear = 1'b0;
    wait_idle();
    chk("clr_push_pulses", n_pulse - b_pulse, 2);
    chk("clr_push_rst_cycles", n_rst - b_rst, 2);
    chk("clr_push_rgb", int'(out_rgb), 12'h123);
    chk("clr_push_idx", int'(pix_index), 1);

    // Reset during a GAP with words queued.
    for (int i = 0; i < 4; i++) send(12'h700 + 12'(i));
    for (int t = 0; t < 50 && !out_add; t++) @(negedge clk_50);
    for (int t = 0; t < 50 && out_add; t++) @(negedge clk_50);
    chk("rstop_in_gap", int'(out_add), 0);
    reset = 1'b1;
    @(negedge clk_50);
    chk("rstop_add", int'(out_add), 0);
    chk("rstop_rgb", int'(out_rgb), 0);
    chk("rstop_idx", int'(pix_index), 0);
    chk("rstop_busy", int'(busy), 0);
    reset = 1'b0;
    b_pulse = n_pulse;
    repeat (40) @(negedge clk_50);
    chk("rstop_no_pulse", n_pulse - b_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
